// File: rtl/dmem_bus_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : dmem_bus_ctrl
// Brief    : Memory-stage data-access controller. It issues single-word
//            requests on the external data bus, drives dstall to the hazard
//            unit and holds load data until the M-stage instruction retires.
// Option   : DMEM_WRITE_BUFFER_EN adds a one-entry posted-write buffer.
// Revision : 1.0 - initial release
// ============================================================================
module dmem_bus_ctrl #(
    parameter int TIMEOUT = 64,
    parameter int CNTW    = 7
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        MemReadM,
    input  logic        MemWriteM,
    input  logic [31:0] AddrM,
    input  logic [31:0] WriteDataM,
    input  logic [3:0]  ByteMaskM,
    input  logic        StallM,
    input  logic        FlushM,
    output logic        dstall,
    output logic [31:0] ReadDataM,
    output logic        DataAbortM,
    output logic        BusReq,
    output logic        BusWrite,
    output logic [31:0] BusAddr,
    output logic [31:0] BusWData,
    output logic [3:0]  BusMask,
    input  logic        BusAck,
    input  logic        BusErr,
    input  logic [31:0] BusRData
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        REQ  = 2'd1,
        DONE = 2'd2
    } state_t;

    localparam logic [CNTW-1:0] C_LAST = CNTW'(TIMEOUT - 1);
    localparam logic [CNTW-1:0] C_ONE  = CNTW'(1);

    state_t          r_state;
    state_t          w_stateNext;
    logic [CNTW-1:0] r_count;
    logic            w_access;
    logic            w_accessEff;
    logic            w_issue;
    logic            w_done;
    logic            w_fail;
    logic            w_posted;
    logic            w_unused;

    // Byte-offset bits never reach the word-addressed bus.
    assign w_unused = ^AddrM[1:0];

    assign w_access = (MemReadM | MemWriteM) & ~FlushM;

`ifdef DMEM_WRITE_BUFFER_EN
    // r_posted: the transfer in flight is a buffered store whose instruction
    // has already left M. r_storeHeld: that store is still sitting in M
    // (front-end stall) and must not be captured a second time.
    logic r_posted;
    logic r_storeHeld;

    assign w_posted    = r_posted;
    assign w_accessEff = w_access & ~r_storeHeld;
    assign dstall      = reset & (((r_state == IDLE) & w_accessEff & ~MemWriteM)
                                 | ((r_state == REQ) & ~r_posted)
                                 | ((r_state == REQ) & r_posted & w_accessEff));

    // Track buffer ownership and the retiring posted store.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_posted    <= 1'b0;
            r_storeHeld <= 1'b0;
        end else begin
            if (w_issue) begin
                r_posted <= MemWriteM;
            end else if (w_done) begin
                r_posted <= 1'b0;
            end
            if (w_issue && MemWriteM) begin
                r_storeHeld <= StallM;
            end else begin
                r_storeHeld <= r_storeHeld & StallM;
            end
        end
    end
`else
    assign w_posted    = 1'b0;
    assign w_accessEff = w_access;
    assign dstall      = reset & (((r_state == IDLE) & w_access) | (r_state == REQ));
`endif

    assign w_issue = (r_state == IDLE) & w_accessEff;
    assign w_done  = (r_state == REQ) & (BusAck | BusErr | (r_count == C_LAST));
    assign w_fail  = (r_state == REQ) & (BusErr | (~BusAck & (r_count == C_LAST)));

    // State register.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_stateNext;
        end
    end

    // Next-state logic; a drained posted store returns straight to IDLE.
    always_comb begin
        w_stateNext = r_state;
        case (r_state)
            IDLE: begin
                if (w_accessEff) begin
                    w_stateNext = REQ;
                end
            end
            REQ: begin
                if (w_done) begin
                    w_stateNext = w_posted ? IDLE : DONE;
                end
            end
            DONE: begin
                if (!StallM) begin
                    w_stateNext = IDLE;
                end
            end
            default: w_stateNext = IDLE;
        endcase
    end

    // Bus request registers, timeout counter, load data and abort pulse.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            BusReq     <= 1'b0;
            BusWrite   <= 1'b0;
            BusAddr    <= 32'd0;
            BusWData   <= 32'd0;
            BusMask    <= 4'd0;
            ReadDataM  <= 32'd0;
            DataAbortM <= 1'b0;
            r_count    <= '0;
        end else begin
            DataAbortM <= 1'b0;
            if (w_issue) begin
                BusReq   <= 1'b1;
                BusWrite <= MemWriteM;
                BusAddr  <= {AddrM[31:2], 2'b00};
                BusWData <= WriteDataM;
                BusMask  <= ByteMaskM;
                r_count  <= '0;
            end else if (r_state == REQ) begin
                if (w_done) begin
                    BusReq <= 1'b0;
                    if (w_fail) begin
                        DataAbortM <= 1'b1;
                        if (!w_posted) begin
                            ReadDataM <= 32'd0;
                        end
                    end else if (!BusWrite) begin
                        ReadDataM <= BusRData;
                    end
                end else begin
                    r_count <= r_count + C_ONE;
                end
            end
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_dmem_bus_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : tb_dmem_bus_ctrl
// Brief    : Self-checking bench for dmem_bus_ctrl with a transaction-level
//            reference model (expected latency, bus fields and load data).
// Revision : 1.0 - initial release
// ============================================================================
module tb_dmem_bus_ctrl;

    localparam int TIMEOUT = 64;

    logic        clk = 1'b0;
    logic        reset = 1'b0;
    logic        MemReadM = 1'b0, MemWriteM = 1'b0, StallM = 1'b0, FlushM = 1'b0;
    logic [31:0] AddrM = '0, WriteDataM = '0, BusRData = '0;
    logic [3:0]  ByteMaskM = '0;
    logic        BusAck = 1'b0, BusErr = 1'b0;
    logic        dstall, DataAbortM, BusReq, BusWrite;
    logic [31:0] ReadDataM, BusAddr, BusWData;
    logic [3:0]  BusMask;

    int          nChecks = 0;
    int          nPass   = 0;
    logic [31:0] expRead = '0;

    dmem_bus_ctrl #(.TIMEOUT(TIMEOUT), .CNTW(7)) dut (
        .clk(clk), .reset(reset),
        .MemReadM(MemReadM), .MemWriteM(MemWriteM), .AddrM(AddrM),
        .WriteDataM(WriteDataM), .ByteMaskM(ByteMaskM), .StallM(StallM),
        .FlushM(FlushM), .dstall(dstall), .ReadDataM(ReadDataM),
        .DataAbortM(DataAbortM), .BusReq(BusReq), .BusWrite(BusWrite),
        .BusAddr(BusAddr), .BusWData(BusWData), .BusMask(BusMask),
        .BusAck(BusAck), .BusErr(BusErr), .BusRData(BusRData)
    );

    always #5 clk = ~clk;

    // One access: present in M at cycle 0, ack (or error) at cycle ackDelay
    // (0 = never, expect timeout), then hold StallM for holdCycles in DONE.
    task automatic run_txn(input bit rd, input bit wr, input logic [31:0] addr,
                           input logic [31:0] wdata, input logic [3:0] mask,
                           input int ackDelay, input bit err,
                           input logic [31:0] rdata, input int holdCycles);
        bit tout;
        bit isWrite;
        bit abortExp;
        int endCyc;
        tout    = (ackDelay == 0);
        endCyc  = tout ? TIMEOUT : ackDelay;
        isWrite = wr;
        @(posedge clk); #1;
        MemReadM = rd; MemWriteM = wr; AddrM = addr; WriteDataM = wdata;
        ByteMaskM = mask; FlushM = 1'b0; StallM = 1'b1; BusAck = 1'b0; BusErr = 1'b0;
        #1;
        nChecks++;
        if (dstall !== 1'b1 || BusReq !== 1'b0) $display("FAIL cyc0 dstall=%b busreq=%b want 1/0", dstall, BusReq);
        else nPass++;
        for (int c = 1; c <= endCyc; c++) begin
            @(posedge clk); #1;
            if (c == endCyc && !tout) begin
                BusAck = err ? 1'($urandom_range(0, 1)) : 1'b1;
                BusErr = err; BusRData = rdata;
            end else begin
                BusAck = 1'b0; BusErr = 1'b0; BusRData = $urandom;
            end
            #1;
            nChecks++;
            if (dstall !== 1'b1 || BusReq !== 1'b1 || BusWrite !== isWrite ||
                BusAddr !== {addr[31:2], 2'b00} || BusWData !== wdata || BusMask !== mask)
                $display("FAIL req cyc%0d got st=%b rq=%b wr=%b a=%h d=%h m=%h want 1 1 %b %h %h %h",
                         c, dstall, BusReq, BusWrite, BusAddr, BusWData, BusMask,
                         isWrite, {addr[31:2], 2'b00}, wdata, mask);
            else nPass++;
        end
        abortExp = err | tout;
        if (abortExp) expRead = 32'd0;
        else if (!isWrite) expRead = rdata;
        for (int j = 0; j <= holdCycles; j++) begin
            @(posedge clk); #1;
            BusAck = (j == 0) ? 1'b0 : 1'($urandom_range(0, 1));
            BusErr = 1'b0; BusRData = $urandom;
            StallM = (j < holdCycles);
            #1;
            nChecks++;
            if (dstall !== 1'b0 || BusReq !== 1'b0 || ReadDataM !== expRead ||
                DataAbortM !== ((j == 0) ? abortExp : 1'b0))
                $display("FAIL done%0d st=%b rq=%b rd=%h ab=%b want 0 0 %h %b", j, dstall,
                         BusReq, ReadDataM, DataAbortM, expRead, (j == 0) ? abortExp : 1'b0);
            else nPass++;
        end
        @(posedge clk); #1;
        MemReadM = 1'b0; MemWriteM = 1'b0; BusAck = 1'b0; StallM = 1'b0;
        #1;
        nChecks++;
        if (dstall !== 1'b0 || BusReq !== 1'b0 || ReadDataM !== expRead || DataAbortM !== 1'b0)
            $display("FAIL idle st=%b rq=%b rd=%h ab=%b want 0 0 %h 0", dstall, BusReq,
                     ReadDataM, DataAbortM, expRead);
        else nPass++;
    endtask

    task automatic test_reset();
        #2;
        nChecks++;
        if (BusReq !== 1'b0 || BusWrite !== 1'b0 || BusAddr !== 32'd0 || BusWData !== 32'd0 ||
            BusMask !== 4'd0 || ReadDataM !== 32'd0 || DataAbortM !== 1'b0 || dstall !== 1'b0)
            $display("FAIL reset rq=%b wr=%b a=%h d=%h m=%h rd=%h ab=%b st=%b want all 0",
                     BusReq, BusWrite, BusAddr, BusWData, BusMask, ReadDataM, DataAbortM, dstall);
        else nPass++;
        @(posedge clk); @(posedge clk); #1;
        reset = 1'b1;
        @(posedge clk); #2;
        nChecks++;
        if (BusReq !== 1'b0 || dstall !== 1'b0) $display("FAIL post_reset rq=%b st=%b want 0 0", BusReq, dstall);
        else nPass++;
    endtask

    task automatic test_load();
        run_txn(1'b1, 1'b0, 32'h100, 32'h0, 4'hF, 3, 1'b0, 32'hDEADBEEF, 0);
    endtask

    task automatic test_store();
        run_txn(1'b0, 1'b1, 32'h207, 32'h12345678, 4'b1000, 2, 1'b0, 32'hFFFF0000, 0);
        // both strobes high: treated as a write, load data untouched
        run_txn(1'b1, 1'b1, 32'h3FC, 32'hA5A5A5A5, 4'b0011, 1, 1'b0, 32'h11111111, 1);
    endtask

    task automatic test_stall_hold();
        run_txn(1'b1, 1'b0, 32'h440, 32'h0, 4'hF, 2, 1'b0, 32'hCAFEF00D, 5);
    endtask

    task automatic test_error_timeout();
        run_txn(1'b1, 1'b0, 32'h500, 32'h0, 4'hF, 0, 1'b0, 32'h0, 0);
        run_txn(1'b1, 1'b0, 32'h600, 32'h0, 4'hF, 2, 1'b0, 32'h87654321, 0);
        run_txn(1'b1, 1'b0, 32'h604, 32'h0, 4'hF, 3, 1'b1, 32'h55555555, 1);
    endtask

    task automatic test_flush();
        @(posedge clk); #1;
        MemReadM = 1'b1; FlushM = 1'b1; StallM = 1'b0; BusAck = 1'b1; AddrM = 32'h700;
        #1;
        nChecks++;
        if (dstall !== 1'b0 || BusReq !== 1'b0) $display("FAIL flush st=%b rq=%b want 0 0", dstall, BusReq);
        else nPass++;
        @(posedge clk); #1;
        MemReadM = 1'b0; FlushM = 1'b0; BusAck = 1'b0;
        #1;
        nChecks++;
        if (BusReq !== 1'b0 || DataAbortM !== 1'b0 || ReadDataM !== expRead)
            $display("FAIL flush_after rq=%b ab=%b rd=%h want 0 0 %h", BusReq, DataAbortM, ReadDataM, expRead);
        else nPass++;
    endtask

    task automatic test_reset_mid_req();
        @(posedge clk); #1;
        MemReadM = 1'b1; AddrM = 32'h800; StallM = 1'b1;
        repeat (2) @(posedge clk);
        #3;
        reset = 1'b0;
        #1;
        nChecks++;
        if (BusReq !== 1'b0 || dstall !== 1'b0 || BusAddr !== 32'd0 || ReadDataM !== 32'd0)
            $display("FAIL reset_mid rq=%b st=%b a=%h rd=%h want 0 0 0 0", BusReq, dstall, BusAddr, ReadDataM);
        else nPass++;
        expRead = 32'd0;
        @(posedge clk); #1;
        MemReadM = 1'b0; StallM = 1'b0; reset = 1'b1;
        for (int i = 0; i < 3; i++) begin
            @(posedge clk); #2;
            nChecks++;
            if (BusReq !== 1'b0 || dstall !== 1'b0) $display("FAIL reset_idle%0d rq=%b st=%b want 0 0", i, BusReq, dstall);
            else nPass++;
        end
    endtask

    task automatic test_random();
        for (int n = 0; n < 25; n++) begin
            bit rd, wr, err;
            int dly;
            rd  = 1'($urandom_range(0, 1));
            wr  = ~rd | (($urandom_range(0, 7) == 0) ? 1'b1 : 1'b0);
`ifdef DMEM_WRITE_BUFFER_EN
            rd = 1'b1; wr = 1'b0;
`endif
            err = ($urandom_range(0, 7) == 0);
            dly = ($urandom_range(0, 11) == 0) ? 0 : int'($urandom_range(1, 6));
            run_txn(rd, wr, $urandom, $urandom, 4'($urandom), dly, err, $urandom,
                    int'($urandom_range(0, 3)));
        end
    endtask

`ifdef DMEM_WRITE_BUFFER_EN
    task automatic test_write_buffer();
        @(posedge clk); #1;
        MemWriteM = 1'b1; AddrM = 32'h900; WriteDataM = 32'h0BADF00D; ByteMaskM = 4'hF; StallM = 1'b0;
        #1;
        nChecks++;
        if (dstall !== 1'b0) $display("FAIL wb_store_stall got %b want 0", dstall);
        else nPass++;
        for (int c = 1; c <= 4; c++) begin
            @(posedge clk); #1;
            MemWriteM = 1'b0; MemReadM = 1'b1; AddrM = 32'hA00; StallM = 1'b1; BusAck = (c == 4);
            #1;
            nChecks++;
            if (dstall !== 1'b1 || BusReq !== 1'b1 || BusWrite !== 1'b1 || BusAddr !== 32'h900)
                $display("FAIL wb_drain%0d st=%b rq=%b wr=%b a=%h want 1 1 1 00000900", c, dstall, BusReq, BusWrite, BusAddr);
            else nPass++;
        end
        @(posedge clk); #1;
        BusAck = 1'b0;
        #1;
        nChecks++;
        if (dstall !== 1'b1 || BusReq !== 1'b0) $display("FAIL wb_gap st=%b rq=%b want 1 0", dstall, BusReq);
        else nPass++;
        @(posedge clk); #1;
        BusAck = 1'b1; BusRData = 32'h13579BDF;
        #1;
        nChecks++;
        if (BusReq !== 1'b1 || BusWrite !== 1'b0 || BusAddr !== 32'hA00)
            $display("FAIL wb_load rq=%b wr=%b a=%h want 1 0 00000a00", BusReq, BusWrite, BusAddr);
        else nPass++;
        @(posedge clk); #1;
        BusAck = 1'b0; StallM = 1'b0;
        #1;
        expRead = 32'h13579BDF;
        nChecks++;
        if (dstall !== 1'b0 || ReadDataM !== expRead) $display("FAIL wb_result st=%b rd=%h want 0 %h", dstall, ReadDataM, expRead);
        else nPass++;
        @(posedge clk); #1;
        MemReadM = 1'b0;
    endtask
`endif

    initial begin
        test_reset();
        test_load();
`ifndef DMEM_WRITE_BUFFER_EN
        test_store();
`else
        test_write_buffer();
`endif
        test_stall_hold();
        test_error_timeout();
        test_flush();
        test_reset_mid_req();
        test_random();
        $display("%0d/%0d checks passed", nPass, nChecks);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/dmem_bus_ctrl.md
Name: dmem_bus_ctrl

Overview:
- Memory-stage data-access controller for the pipelined ARM core.
- Produces the `dstall` signal that the hazard unit consumes; issues single-word requests on the external data bus.
- Holds load data until the M-stage instruction retires, so an access is never re-issued while the pipeline is frozen by an instruction-side stall.

Parameters:
- TIMEOUT, 64: max cycles in REQ before the access is aborted; must be ≥2.
- CNTW, 7: width of the timeout counter; must satisfy 2^CNTW > TIMEOUT.

Ports:
- clk  in  1  core clock.
- reset  in  1  asynchronous, active-low reset.
- MemReadM  in  1  M-stage load.
- MemWriteM  in  1  M-stage store.
- AddrM  in  32  byte address; bits [1:0] ignored on bus.
- WriteDataM  in  32  store data.
- ByteMaskM  in  4  byte enables.
- StallM  in  1  M stage held this cycle (dstall or istall, from hazard unit).
- FlushM  in  1  M-stage instruction squashed; no access starts.
- dstall  out  1  data-side stall to hazard unit.
- ReadDataM  out  32  load result.
- DataAbortM  out  1  one-cycle pulse on bus error or timeout.
- BusReq  out  1  request valid.
- BusWrite  out  1  1 = write.
- BusAddr  out  32  word address, bits [1:0] = 0.
- BusWData  out  32  write data.
- BusMask  out  4  byte enables.
- BusAck  in  1  transfer complete; BusRData valid.
- BusErr  in  1  transfer failed (sampled with BusAck or alone).
- BusRData  in  32  read data.

Behaviour:
- Reset (reset=0): state IDLE, BusReq=0, all bus outputs 0, ReadDataM=0, DataAbortM=0, counter=0. Applies immediately, including mid-REQ; an outstanding bus transfer is abandoned.
- `access` = (MemReadM|MemWriteM) & ~FlushM.
- dstall is combinational: `(state==IDLE & access) | state==REQ`.
- IDLE:
  - If `access`: register bus outputs from M-stage inputs, BusReq←1, go to REQ, counter←0.
  - Otherwise remain in IDLE.
- REQ:
  - BusReq and all bus outputs are held stable until the cycle of BusAck or BusErr.
  - BusAck & ~BusErr: ReadDataM←BusRData on loads; ReadDataM unchanged on stores. BusReq←0, go to DONE.
  - BusErr, or counter==TIMEOUT-1 with no ack: BusReq←0, ReadDataM←0, DataAbortM pulses the next cycle, go to DONE.
  - Otherwise counter increments.
- DONE:
  - dstall=0 and ReadDataM is held.
  - StallM=1: stay in DONE; no re-issue.
  - StallM=0: go to IDLE. The next M instruction is evaluated in the following cycle.
- Latency: access present at cycle 0 → BusReq=1 at cycle 1 → ack at cycle k → dstall=0 and ReadDataM valid at cycle k+1. Minimum load-to-use stall is 2 cycles.
- FlushM asserted while in REQ: the transfer still completes (the bus cannot be cancelled). The result is discarded by the pipeline.
- BusAck while in IDLE or DONE is ignored.
- Both MemReadM and MemWriteM high is illegal; it is treated as a write.

Optional Feature:
- Macro: DMEM_WRITE_BUFFER_EN.
- Defined: adds a one-entry posted-write buffer.
  - A store in IDLE with an empty buffer captures addr/data/mask into the buffer, with dstall=0. The buffer drains on the bus in the background and frees on BusAck.
  - Any access while the buffer is full asserts dstall until it drains; loads never bypass a pending store.
  - Drain errors and timeouts still pulse DataAbortM, imprecise.
  - Reset empties the buffer.
- Undefined: stores behave exactly like loads (stall until ack). No buffer logic is present.

Test Plan:
- Load, AddrM=0x100, bus acks after 3 cycles with 0xDEADBEEF → BusReq cycles 1-3, BusAddr=0x100, dstall cycles 0-3, ReadDataM=0xDEADBEEF at cycle 4.
- Store, AddrM=0x207, WriteDataM=0x12345678, ByteMaskM=0b1000 → BusWrite=1, BusAddr=0x204, BusMask=0b1000, exactly one bus transfer.
- Load acked while StallM stays high 5 more cycles → state DONE, BusReq stays 0 (no re-issue), ReadDataM stable, dstall=0 throughout.
- Load, BusAck never arrives, TIMEOUT=64 → BusReq drops after 64 cycles, DataAbortM high one cycle, ReadDataM=0.
- reset pulsed low during REQ → BusReq=0 and dstall=0 immediately; after release with no access, stays in IDLE.
- DMEM_WRITE_BUFFER_EN defined, store then load back-to-back, store ack delayed 4 cycles → store causes 0 stall cycles, load stalls until the buffer drains, then issues its own request.
